// File: rtl/fejkon_pcie_msi_pkg.sv
// Shared constants for the coalescing MSI generator: CSR word offsets and FSM states.
package fejkon_pcie_msi_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_THRESH  = 2'd1;
  localparam logic [1:0] REG_HOLDOFF = 2'd2;
  localparam logic [1:0] REG_COUNT   = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, GAP} msi_state_t;

endpackage

// File: rtl/fejkon_msi_coalesce_chan.sv
// One coalescing channel: config registers, saturating event counter, holdoff timer, due flag.
module fejkon_msi_coalesce_chan
  import fejkon_pcie_msi_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMER_W = 16,
  parameter int DW      = (CNT_W > TIMER_W) ? CNT_W : TIMER_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               event_strobe,
  input  logic               wr_en,
  input  logic [1:0]         wr_reg,
  input  logic [DW-1:0]      wr_data,
  input  logic               ack_clear,
  output logic               enable,
  output logic [CNT_W-1:0]   thresh,
  output logic [TIMER_W-1:0] holdoff,
  output logic [CNT_W-1:0]   count,
  output logic               due
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic               enable_reg;
  logic [CNT_W-1:0]   thresh_reg;
  logic [TIMER_W-1:0] holdoff_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0]   thresh_eff;
  logic               count_clear;

  assign count_clear = ack_clear || (wr_en && wr_reg == REG_COUNT);

  // A clear coinciding with an event leaves that event pending and restarts the holdoff.
  always_comb begin
    count_next = count_reg;
    if (count_clear)
      count_next = event_strobe ? CNT_W'(1) : '0;
    else if (event_strobe && count_reg != CNT_MAX)
      count_next = count_reg + 1'b1;

    timer_next = timer_reg;
    if (count_next == '0)
      timer_next = '0;
    else if (count_reg == '0 || count_clear)
      timer_next = holdoff_reg;
    else if (timer_reg != '0)
      timer_next = timer_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_reg  <= 1'b0;
      thresh_reg  <= CNT_W'(1);
      holdoff_reg <= '0;
      count_reg   <= '0;
      timer_reg   <= '0;
    end else begin
      if (wr_en) begin
        case (wr_reg)
          REG_CTRL:    enable_reg  <= wr_data[0];
          REG_THRESH:  thresh_reg  <= wr_data[CNT_W-1:0];
          REG_HOLDOFF: holdoff_reg <= wr_data[TIMER_W-1:0];
          default:     ;
        endcase
      end
      count_reg <= count_next;
      timer_reg <= timer_next;
    end
  end

  assign thresh_eff = (thresh_reg == '0) ? CNT_W'(1) : thresh_reg;
  assign due = enable_reg && (count_reg != '0) &&
               ((count_reg >= thresh_eff) || (timer_reg == '0));

  assign enable  = enable_reg;
  assign thresh  = thresh_reg;
  assign holdoff = holdoff_reg;
  assign count   = count_reg;

endmodule

// File: rtl/fejkon_pcie_msi_coalesce.sv
// Multi-channel MSI generator: CSR slave, round-robin arbiter and MSI request FSM.
module fejkon_pcie_msi_coalesce
  import fejkon_pcie_msi_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MSI_BASE = 0,
  parameter int CNT_W    = 8,
  parameter int TIMER_W  = 16,
  localparam int AW      = $clog2(CHANNELS) + 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] event_strobe,
  input  logic                msi_enable,
  input  logic [AW-1:0]       csr_address,
  input  logic                csr_read,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  output logic [31:0]         csr_readdata,
  output logic                csr_readdatavalid,
  output logic                app_msi_req,
  output logic [4:0]          app_msi_num,
  output logic [2:0]          app_msi_tc,
  input  logic                app_msi_ack
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW   = (CNT_W > TIMER_W) ? CNT_W : TIMER_W;

  logic [CH_W-1:0]    csr_ch;
  logic [1:0]         csr_reg;
  logic               csr_ch_valid;
  logic [31:0]        rd_data;
  logic               unused_wdata;

  logic [CHANNELS-1:0] wr_sel, ack_clear, due_vec, enable_vec;
  logic [CNT_W-1:0]    thresh_arr  [CHANNELS];
  logic [TIMER_W-1:0]  holdoff_arr [CHANNELS];
  logic [CNT_W-1:0]    count_arr   [CHANNELS];

  msi_state_t      state_reg;
  logic [CH_W-1:0] ch_reg, last_reg, pick, idx;
  logic            pick_valid, ack_hit;

  assign csr_reg      = csr_address[1:0];
  assign unused_wdata = ^csr_writedata;

  if (AW > 2) begin : g_ch_addr
    assign csr_ch = csr_address[AW-1:2];
  end else begin : g_ch_single
    assign csr_ch = '0;
  end

  assign csr_ch_valid = ({{(32-CH_W){1'b0}}, csr_ch} < 32'(CHANNELS));
  assign ack_hit      = (state_reg == REQ) && app_msi_ack;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign wr_sel[gi]    = csr_write && csr_ch_valid && (csr_ch == CH_W'(gi));
    assign ack_clear[gi] = ack_hit && (ch_reg == CH_W'(gi));

    fejkon_msi_coalesce_chan #(
      .CNT_W   (CNT_W),
      .TIMER_W (TIMER_W),
      .DW      (DW)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .event_strobe (event_strobe[gi]),
      .wr_en        (wr_sel[gi]),
      .wr_reg       (csr_reg),
      .wr_data      (csr_writedata[DW-1:0]),
      .ack_clear    (ack_clear[gi]),
      .enable       (enable_vec[gi]),
      .thresh       (thresh_arr[gi]),
      .holdoff      (holdoff_arr[gi]),
      .count        (count_arr[gi]),
      .due          (due_vec[gi])
    );
  end

  always_comb begin
    rd_data = '0;
    if (csr_ch_valid) begin
      case (csr_reg)
        REG_CTRL:    rd_data[0]           = enable_vec[csr_ch];
        REG_THRESH:  rd_data[CNT_W-1:0]   = thresh_arr[csr_ch];
        REG_HOLDOFF: rd_data[TIMER_W-1:0] = holdoff_arr[csr_ch];
        default:     rd_data[CNT_W-1:0]   = count_arr[csr_ch];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      csr_readdata      <= csr_read ? rd_data : '0;
      csr_readdatavalid <= csr_read;
    end
  end

  // Scan from the channel after the last grant; descending k lets the nearest due channel win.
  always_comb begin
    pick_valid = 1'b0;
    pick       = last_reg;
    idx        = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = CH_W'((32'(last_reg) + 32'(k) + 32'd1) % 32'(CHANNELS));
      if (due_vec[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      ch_reg      <= '0;
      last_reg    <= CH_W'(CHANNELS - 1);
      app_msi_req <= 1'b0;
      app_msi_num <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (msi_enable && pick_valid) begin
            ch_reg      <= pick;
            last_reg    <= pick;
            app_msi_req <= 1'b1;
            app_msi_num <= 5'(MSI_BASE) + 5'(pick);
            state_reg   <= REQ;
          end
        end
        REQ: begin
          if (app_msi_ack) begin
            app_msi_req <= 1'b0;
            state_reg   <= GAP;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign app_msi_tc = 3'd0;

endmodule

// File: tb/tb_fejkon_pcie_msi_coalesce.sv
// Directed bench for the coalescing MSI generator with scoreboard queues for MSI numbers and CSR reads.
module tb_fejkon_pcie_msi_coalesce;

  localparam int CH   = 4;
  localparam int BASE = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  event_strobe;
  logic        msi_enable;
  logic [3:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic        csr_readdatavalid;
  logic        app_msi_req;
  logic [4:0]  app_msi_num;
  logic [2:0]  app_msi_tc;
  logic        app_msi_ack;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd_q[$];

  fejkon_pcie_msi_coalesce #(
    .CHANNELS (CH),
    .MSI_BASE (BASE),
    .CNT_W    (8),
    .TIMER_W  (16)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .event_strobe      (event_strobe),
    .msi_enable        (msi_enable),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .app_msi_req       (app_msi_req),
    .app_msi_num       (app_msi_num),
    .app_msi_tc        (app_msi_tc),
    .app_msi_ack       (app_msi_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
    $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input int ch, input int r, input logic [31:0] data);
    csr_address   = 4'(ch * 4 + r);
    csr_writedata = data;
    csr_write     = 1'b1;
    tick();
    csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input int ch, input int r, input logic [31:0] expv);
    rd_q.push_back(expv);
    csr_address = 4'(ch * 4 + r);
    csr_read    = 1'b1;
    tick();
    csr_read    = 1'b0;
    chk({tag, "_rdv"}, 32'(csr_readdatavalid), 32'd1);
    chk(tag, csr_readdata, rd_q.pop_front());
  endtask

  task automatic strobe(input logic [3:0] mask);
    event_strobe = mask;
    tick();
    event_strobe = '0;
  endtask

  task automatic ack();
    app_msi_ack = 1'b1;
    tick();
    app_msi_ack = 1'b0;
  endtask

  // Waits at most 'bound' cycles for a request, then checks it against the scoreboard head.
  task automatic wait_req(input string tag, input int bound, output int waited);
    logic [31:0] expv;
    waited = 0;
    while (!app_msi_req && waited < bound) begin
      tick();
      waited++;
    end
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
    chk({tag, "_req"}, 32'(app_msi_req), 32'd1);
    chk({tag, "_num"}, 32'(app_msi_num), expv);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      tick();
      if (app_msi_req) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int w;
    reset_n       = 1'b0;
    event_strobe  = '0;
    msi_enable    = 1'b1;
    csr_address   = '0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = '0;
    app_msi_ack   = 1'b0;
    repeat (3) tick();
    chk("rst_req",  32'(app_msi_req), 32'd0);
    chk("rst_num",  32'(app_msi_num), 32'd0);
    chk("rst_tc",   32'(app_msi_tc), 32'd0);
    chk("rst_rdv",  32'(csr_readdatavalid), 32'd0);
    chk("rst_rdat", csr_readdata, 32'd0);
    reset_n = 1'b1;
    tick();
    csr_rd("rst_thresh", 2, 1, 32'd1);
    csr_rd("rst_holdoff", 2, 2, 32'd0);
    csr_rd("rst_ctrl", 2, 0, 32'd0);

    // Threshold 4 but holdoff 0: the first event already makes ch1 due.
    csr_wr(1, 1, 32'd4);
    csr_wr(1, 0, 32'd1);
    exp_q.push_back(32'(BASE + 1));
    strobe(4'b0010);
    wait_req("t1", 4, w);
    chk("t1_latency", 32'(w), 32'd1);
    repeat (3) strobe(4'b0010);
    chk("t1_hold_req", 32'(app_msi_req), 32'd1);
    chk("t1_hold_num", 32'(app_msi_num), 32'(BASE + 1));
    ack();
    chk("t1_gap", 32'(app_msi_req), 32'd0);
    csr_rd("t1_count", 1, 3, 32'd0);
    csr_wr(1, 0, 32'd0);

    // Holdoff 100 with threshold 8: one event fires only after the timer runs out.
    csr_wr(0, 1, 32'd8);
    csr_wr(0, 2, 32'd100);
    csr_wr(0, 0, 32'd1);
    exp_q.push_back(32'(BASE));
    strobe(4'b0001);
    quiet("t2_quiet", 100);
    wait_req("t2", 3, w);
    chk("t2_latency", 32'(w), 32'd1);
    ack();
    csr_rd("t2_count", 0, 3, 32'd0);

    // Threshold reached before a long holdoff.
    csr_wr(3, 1, 32'd4);
    csr_wr(3, 2, 32'd1000);
    csr_wr(3, 0, 32'd1);
    repeat (3) strobe(4'b1000);
    quiet("t3_below_thr", 5);
    exp_q.push_back(32'(BASE + 3));
    strobe(4'b1000);
    wait_req("t3", 3, w);
    chk("t3_latency", 32'(w), 32'd1);
    ack();

    // Fresh reset: pointer back at the last channel, so ch0 wins first.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    csr_wr(0, 0, 32'hFFFF_FFFF);
    csr_wr(2, 0, 32'd1);
    csr_wr(3, 0, 32'd1);
    csr_rd("ctrl_unused", 0, 0, 32'd1);
    msi_enable = 1'b0;
    strobe(4'b1101);
    quiet("t5_gated", 5);
    exp_q.push_back(32'(BASE + 0));
    exp_q.push_back(32'(BASE + 2));
    exp_q.push_back(32'(BASE + 3));
    exp_q.push_back(32'(BASE + 0));
    msi_enable = 1'b1;
    wait_req("rr0", 2, w);
    chk("t5_latency", 32'(w), 32'd1);
    ack();
    chk("rr0_gap", 32'(app_msi_req), 32'd0);
    strobe(4'b0001);
    wait_req("rr1", 3, w);
    chk("rr1_spacing", 32'(w), 32'd1);
    ack();
    chk("rr1_gap", 32'(app_msi_req), 32'd0);
    wait_req("rr2", 3, w);
    chk("rr2_spacing", 32'(w), 32'd2);
    ack();
    chk("rr2_gap", 32'(app_msi_req), 32'd0);
    wait_req("rr3", 3, w);
    chk("rr3_spacing", 32'(w), 32'd2);
    ack();

    // Event on ch2 in the same cycle as its ack keeps one event pending.
    exp_q.push_back(32'(BASE + 2));
    strobe(4'b0100);
    wait_req("t4a", 3, w);
    app_msi_ack  = 1'b1;
    event_strobe = 4'b0100;
    tick();
    app_msi_ack  = 1'b0;
    event_strobe = '0;
    chk("t4_gap", 32'(app_msi_req), 32'd0);
    csr_rd("t4_count", 2, 3, 32'd1);
    exp_q.push_back(32'(BASE + 2));
    wait_req("t4b", 3, w);
    chk("t4_spacing", 32'(w), 32'd1);
    ack();

    // COUNT write clears pending events.
    msi_enable = 1'b0;
    repeat (2) strobe(4'b1000);
    csr_rd("cnt_pre_clr", 3, 3, 32'd2);
    csr_wr(3, 3, 32'd0);
    csr_rd("cnt_post_clr", 3, 3, 32'd0);
    msi_enable = 1'b1;
    quiet("cnt_clr_quiet", 4);

    // Disabled channel saturates, then becomes eligible immediately on enable.
    event_strobe = 4'b0010;
    repeat (300) tick();
    event_strobe = '0;
    chk("sat_no_req", 32'(app_msi_req), 32'd0);
    csr_rd("sat_count", 1, 3, 32'd255);
    exp_q.push_back(32'(BASE + 1));
    csr_wr(1, 0, 32'd1);
    wait_req("reen", 3, w);
    chk("reen_latency", 32'(w), 32'd1);

    // Reset in the middle of REQ, away from any clock edge.
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_async_req", 32'(app_msi_req), 32'd0);
    chk("rst_async_num", 32'(app_msi_num), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    csr_rd("rst_count", 1, 3, 32'd0);
    csr_rd("rst_ctrl1", 1, 0, 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
